// File: rtl/conv_x_streamer.sv
// Memory-backed stream source. A control master loads N*V words, pulses start,
// and the words are replayed in address order over a valid/ready handshake.
module conv_x_streamer #(
    parameter  int T  = 16,
    parameter  int N  = 128,
    parameter  int V  = 78,
    localparam int D  = N * V,
    localparam int AW = $clog2(N * V)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [T-1:0]  wr_data_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [T-1:0]  x_data_o,
    output logic          x_valid_o,
    input  logic          x_ready_i,
    output logic          x_last_o
);

    localparam int          IW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW:0] D_C    = (AW + 1)'(D);
    localparam logic [AW:0] LAST_C = (AW + 1)'(D - 1);
    localparam logic [IW-1:0] NL_C = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    // rd_q is one bit wider than the address so it can reach D ("all loaded")
    logic [AW:0]    rd_q, rd_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           fin_q, fin_d;
    logic [T-1:0]   x_data_q, x_data_d;
    logic           x_valid_q, x_valid_d;
    logic           x_last_q, x_last_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           wr_ok_s;
    logic [T-1:0]   rd_word_s;

    logic [T-1:0]   mem_q [D];

    assign wr_ok_s   = wr_en_i && !busy_q && ({1'b0, wr_addr_i} < D_C);
    assign rd_word_s = mem_q[rd_q[AW-1:0]];

    // Vector memory: no reset, contents survive a run reset.
    always_ff @(posedge clk_i) begin
        if (wr_ok_s) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Next-state, counters and output-stage loading.
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        idx_d     = idx_q;
        fin_d     = fin_q;
        x_data_d  = x_data_q;
        x_valid_d = x_valid_q;
        x_last_d  = x_last_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    rd_d    = '0;
                    idx_d   = '0;
                    fin_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                // fin_q marks that the staged word is the final one of the run
                if (x_valid_q && x_ready_i && fin_q) begin
                    state_d   = S_DONE;
                    x_valid_d = 1'b0;
                    x_last_d  = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else if ((!x_valid_q || x_ready_i) && (rd_q < D_C)) begin
                    x_data_d  = rd_word_s;
                    x_last_d  = (idx_q == NL_C);
                    x_valid_d = 1'b1;
                    fin_d     = (rd_q == LAST_C);
                    rd_d      = rd_q + (AW + 1)'(1);
                    idx_d     = (idx_q == NL_C) ? '0 : idx_q + IW'(1);
                end else begin
                    x_valid_d = x_valid_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                x_valid_d = 1'b0;
                x_last_d  = 1'b0;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            rd_q      <= '0;
            idx_q     <= '0;
            fin_q     <= 1'b0;
            x_data_q  <= '0;
            x_valid_q <= 1'b0;
            x_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            idx_q     <= idx_d;
            fin_q     <= fin_d;
            x_data_q  <= x_data_d;
            x_valid_q <= x_valid_d;
            x_last_q  <= x_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign x_data_o  = x_data_q;
    assign x_valid_o = x_valid_q;
    assign x_last_o  = x_last_q;

endmodule

// File: doc/conv_x_streamer.md
# conv_x_streamer

Memory-backed stream source that feeds input vectors into a convolution core such as `conv_128_8_16_1` over the `x_data`/`x_valid`/`x_ready` handshake. A control master loads `V` vectors of `N` words each through a simple write port and pulses `start`. The block then replays all words in address order with full back-pressure support and marks the last word of each vector. It replaces the bench-side input driver for on-chip, self-contained layer runs.

## Interface
- `T`, 16, word width in bits
- `N`, 128, words per input vector
- `V`, 78, vectors per run; memory depth `D = N*V`
- `AW`, `$clog2(N*V)`, address width (derived, not overridden)

- `clk` in 1 — single clock, all logic on rising edge
- `reset` in 1 — asynchronous, active-high; clears all control state and outputs
- `wr_en` in 1 — write strobe for the vector memory
- `wr_addr` in AW — write address, 0..D-1
- `wr_data` in T — write data
- `start` in 1 — begin a run (sampled when idle)
- `busy` out 1 — run in progress
- `done` out 1 — one-cycle pulse at end of run
- `x_data` out T — stream word to the convolution core
- `x_valid` out 1 — `x_data` is valid
- `x_ready` in 1 — consumer accepts the word
- `x_last` out 1 — high with the final word of each vector (word index `N-1` within the vector)

## Operation
- Storage: `D`×`T` register array or inferred RAM with no reset. Contents survive `reset`.
- Writes: on a rising edge with `wr_en=1`, `busy=0` and `wr_addr<D`, `mem[wr_addr] <= wr_data`.
  - Writes while `busy=1` are ignored.
  - Writes with `wr_addr>=D` are ignored.
- FSM states:
  - IDLE: `busy=0`. On `start=1`, go to RUN; read address is 0, word counter is 0.
  - RUN: streams `mem[0..D-1]` in order. After the handshake on word `D-1`, go to DONE.
  - DONE: lasts one cycle. `done=1`, `busy=0`. Then return to IDLE.
- Output register: one-entry skid/prefetch stage (`x_data`, `x_valid`, `x_last`).
  - Loads the next word when `!x_valid || x_ready`, provided unread words remain.
  - Read address increments on each load.
- `x_last` = 1 when the loaded word's index mod `N` equals `N-1`.
- Counters:
  - Read address: 0..D-1.
  - Within-vector index: 0..N-1, wraps to 0 after `N-1`.
  - Both restart at 0 on every `start`.
- `start` while `busy=1` or in DONE is ignored.
- `start` and `wr_en` in the same idle cycle: the write completes, then the run starts. Word 0 reflects the new data if `wr_addr` is 0 (write-before-read ordering).

## Timing
- Reset values: `busy=0`, `done=0`, `x_valid=0`, `x_last=0`, `x_data=0`. FSM in IDLE, counters 0.
- Latency:
  - `start` sampled at edge k → `busy=1` after k.
  - `x_valid=1` with word 0 after edge k+1.
- Throughput: with `x_ready` held at 1, one word per cycle and no bubbles.
- Back-pressure: while `x_valid=1 && x_ready=0`, `x_data`/`x_last`/`x_valid` stay stable. No word is skipped or duplicated.
- A word transfers on a rising edge where `x_valid && x_ready`.
- `x_valid` never drops without a handshake once asserted.
- End of run:
  - The final handshake (word `D-1`) happens at edge m.
  - After m: `x_valid=0`, `busy=0`, `done=1` for exactly one cycle.
  - After m+1: `done=0`.
- `x_data` when `x_valid=0`: holds its last value (0 after reset). Consumers must not sample it.
- Reset mid-run: the next cycle shows all outputs at their reset values and no `done` pulse. A later `start` replays from word 0 with the memory intact.

## Test plan
1. Load and stream (`N=8`, `V=3`): load `mem[i]=i`, pulse `start`, hold `x_ready=1`.
   - Expect words 0..23 on 24 consecutive cycles starting 2 edges after `start`.
   - `x_last` high on words 7, 15, 23.
   - `done` pulses 1 cycle after word 23; `busy` falls at the same time.
2. Random back-pressure: same load, `x_ready` randomized per cycle (~50%).
   - Accepted sequence is exactly 0..23.
   - `x_data` and `x_last` stay stable across every stalled cycle.
3. Ignored commands: during a run, pulse `start` and write `mem[0]=0xBEEF`.
   - The run is unaffected: 24 words, one `done`.
   - A second run still emits word 0 = 0.
4. Reset mid-run: assert `reset` after 5 handshakes.
   - Outputs return to 0 and there is no `done`.
   - Re-`start` emits 0..23 from the preserved memory.
5. Write boundary: write to `wr_addr=24` with `D=24`.
   - Memory is unchanged and a full run matches scenario 1.
6. System (defaults `N=128`, `V=78`): load the 9984 input words from the layer input file and connect to `conv_128_8_16_1` with randomized `y_ready`.
   - All 9438 outputs match the expected file with zero errors.
